udt_ctrl_axil_master: RTL and testbench
=======================================

Name: udt_ctrl_axil_master

Overview:
- AXI-Lite master that drives the UDT configuration slave's control register space from a simple command/response stream.
- A host-side sequencer (soft CPU bridge or test FSM) issues single writes, single reads, or poll-until-match reads, for example waiting for the connection state to reach CONNECTED.
- The block sits between the host command source and the `ctrl_s_axi_*` port of the UDT configuration block.
- One transaction is outstanding at a time.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles allowed per AXI phase wait before abort.
- POLL_INTERVAL, 16, idle cycles between successive poll reads.
- MAX_POLLS, 256, poll reads attempted before reporting a poll failure.
- ADDR_W, 32, AXI address width.

Ports:
- ctrl_m_axi_aclk  in  1  clock.
- ctrl_m_axi_aresetn  in  1  reset; asynchronous, active-low (already decided).
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  2  00 write, 01 read, 10 poll, 11 reserved (treated as read).
- cmd_addr  in  ADDR_W  register address (0 connect, 1 snd buf, 2 rev buf, 3 flight, 4 MSS, 5 init seq, 6 close, 7 status).
- cmd_wdata  in  32  write data.
- cmd_mask  in  32  poll compare mask.
- cmd_expect  in  32  poll expected value.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  32  read data, or last polled value.
- rsp_resp  out  2  AXI BRESP/RRESP of the last beat.
- rsp_status  out  2  00 ok, 01 timeout, 10 poll exhausted.
- busy  out  1  high whenever not IDLE.
- ctrl_m_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready  standard AXI-Lite master set, 32-bit data; wstrb is always 4'hF.

Behaviour:
- Reset values: all valid/ready outputs 0, rsp_* 0, busy 0, state IDLE, counters 0.
- Reset mid-transaction aborts immediately; no response is produced.
- State machine states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, POLL_GAP, RESP.
- IDLE:
  - cmd_ready=1. On cmd_valid the command fields are latched.
  - Write → WR_REQ. Read or poll → RD_REQ, with poll_cnt cleared.
  - cmd_ready drops the cycle after acceptance.
- WR_REQ:
  - awvalid and wvalid are asserted together in the first cycle.
  - Each valid drops independently on its own handshake (aw_done, w_done flags). Accepting AW and W in either order or the same cycle is supported.
  - When both are done → WR_RESP, with bready=1.
- WR_RESP: bvalid&bready captures bresp into rsp_resp → RESP, status ok.
- RD_REQ: arvalid until arready → RD_DATA, with rready=1.
- RD_DATA:
  - rvalid captures rdata and rresp.
  - Read → RESP.
  - Poll:
    - If (rdata&mask)==(expect&mask) → RESP, status ok.
    - Else poll_cnt+1. If poll_cnt+1==MAX_POLLS → RESP, status 10. Otherwise → POLL_GAP.
  - An RRESP error during a poll ends the poll: → RESP, status ok, rsp_resp carries the error.
- POLL_GAP: waits POLL_INTERVAL cycles, then → RD_REQ.
- RESP:
  - rsp_valid held with all rsp fields stable until rsp_ready → IDLE.
  - The next command may be accepted no earlier than the cycle after.
- Timeout:
  - A 16-bit phase counter clears on entry to WR_REQ, WR_RESP, RD_REQ and RD_DATA, and increments each cycle while waiting.
  - Reaching TIMEOUT_CYCLES:
    - all AXI valids/readys drop;
    - status 01, rsp_resp=2'b10;
    - → RESP.
  - This is error recovery only; the slave requires reset afterwards.
- Poll gap counter does not count toward the timeout.

Decomposition:
- Shared package:
  - cmd_op encodings;
  - rsp_status encodings;
  - register address map 0..7;
  - UDT state codes (INIT 0x0, CONNECTING 0x1, CONNECTED 0x10, CLOSING 0x100, CLOSED 0x1000);
  - configuration error codes 0..9.
- One natural sub-module: udt_axil_wr_chan, which handles AW/W independent handshake plus the B capture.

Test Plan:
- Write to addr 1, data 16384, slave awready 2 cycles before wready → one AW and one W handshake, wstrb F. Response status 00, bresp 00.
- Read addr 7, slave returns 0x0000_0005 with 3-cycle rvalid delay → rsp_rdata 0x5, status 00, arvalid held until arready.
- Poll addr 7, mask FFFF_FFFF, expect 0x10; slave returns 0x1, 0x1, then 0x10 → exactly 3 AR handshakes, at least POLL_INTERVAL idle cycles between reads, rsp_rdata 0x10, status 00.
- Poll with MAX_POLLS=4 and slave always returning 0x1 → 4 reads, status 10, rsp_rdata 0x1.
- Slave never asserts bvalid on a write → after TIMEOUT_CYCLES, status 01, rsp_resp 10, bready low, busy low after rsp_ready.
- Assert reset during RD_DATA → all outputs 0 asynchronously. After release, a read command completes normally.

Source files
------------

// File: rtl/udt_ctrl_axil_master_pkg.sv
// udt_ctrl_axil_master_pkg: shared encodings for the UDT control-register AXI-Lite master
package udt_ctrl_axil_master_pkg;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01, OP_POLL = 2'b10, OP_RSVD = 2'b11} cmd_op_e;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_TIMEOUT = 2'b01, ST_POLL_FAIL = 2'b10} rsp_status_e;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, POLL_GAP, RESP} state_e;
  typedef enum logic [2:0] {
    REG_CONNECT, REG_SND_BUF, REG_REV_BUF, REG_FLIGHT, REG_MSS, REG_INIT_SEQ, REG_CLOSE, REG_STATUS
  } reg_addr_e;
  typedef enum logic [31:0] {
    UDT_INIT = 32'h0, UDT_CONNECTING = 32'h1, UDT_CONNECTED = 32'h10,
    UDT_CLOSING = 32'h100, UDT_CLOSED = 32'h1000
  } udt_state_e;
  typedef enum logic [3:0] {
    ERR_NONE, ERR_BAD_ADDR, ERR_BAD_STATE, ERR_BAD_MSS, ERR_BAD_BUF,
    ERR_BAD_FLIGHT, ERR_BAD_SEQ, ERR_NOT_CONNECTED, ERR_BUSY, ERR_CLOSED
  } cfg_err_e;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  function automatic logic poll_hit(input logic [31:0] v, input logic [31:0] m, input logic [31:0] e);
    return ((v ^ e) & m) == 32'h0;
  endfunction
endpackage

// File: rtl/udt_ctrl_axil_master_wr_chan.sv
// udt_axil_wr_chan: AW/W issued together, each dropped on its own handshake, then B acceptance
module udt_axil_wr_chan (
  input  logic ctrl_m_axi_aclk,
  input  logic ctrl_m_axi_aresetn,
  input  logic req,
  input  logic resp,
  input  logic awready,
  input  logic wready,
  input  logic bvalid,
  output logic awvalid,
  output logic wvalid,
  output logic bready,
  output logic req_done,
  output logic b_done
);
  logic aw_done, w_done;
  assign awvalid  = req & ~aw_done;
  assign wvalid   = req & ~w_done;
  assign bready   = resp;
  assign req_done = req & (aw_done | awready) & (w_done | wready);
  assign b_done   = resp & bvalid;
  always_ff @(posedge ctrl_m_axi_aclk or negedge ctrl_m_axi_aresetn) begin
    if (!ctrl_m_axi_aresetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      aw_done <= req & (aw_done | awready);
      w_done  <= req & (w_done | wready);
    end
  end
endmodule

// File: rtl/udt_ctrl_axil_master.sv
// udt_ctrl_axil_master: AXI-Lite master turning write/read/poll commands into single
// outstanding transactions on the UDT configuration slave, with per-phase timeout.
module udt_ctrl_axil_master
  import udt_ctrl_axil_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int POLL_INTERVAL  = 16,
  parameter int MAX_POLLS      = 256,
  parameter int ADDR_W         = 32
) (
  input  logic              ctrl_m_axi_aclk,
  input  logic              ctrl_m_axi_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [31:0]       cmd_mask,
  input  logic [31:0]       cmd_expect,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [1:0]        rsp_status,
  output logic              busy,
  output logic [ADDR_W-1:0] ctrl_m_axi_awaddr,
  output logic              ctrl_m_axi_awvalid,
  input  logic              ctrl_m_axi_awready,
  output logic [31:0]       ctrl_m_axi_wdata,
  output logic [3:0]        ctrl_m_axi_wstrb,
  output logic              ctrl_m_axi_wvalid,
  input  logic              ctrl_m_axi_wready,
  input  logic [1:0]        ctrl_m_axi_bresp,
  input  logic              ctrl_m_axi_bvalid,
  output logic              ctrl_m_axi_bready,
  output logic [ADDR_W-1:0] ctrl_m_axi_araddr,
  output logic              ctrl_m_axi_arvalid,
  input  logic              ctrl_m_axi_arready,
  input  logic [31:0]       ctrl_m_axi_rdata,
  input  logic [1:0]        ctrl_m_axi_rresp,
  input  logic              ctrl_m_axi_rvalid,
  output logic              ctrl_m_axi_rready
);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(POLL_INTERVAL - 1);
  localparam logic [15:0] POLLS    = 16'(MAX_POLLS);
  state_e state, state_n;
  logic ready_en, accept, wr_req_done, wr_b_done, tmo, tmo_fire, rd_stop, poll_last, is_poll;
  logic [1:0] op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, mask_q, expect_q;
  logic [15:0] phase_cnt, gap_cnt, poll_cnt;
  udt_axil_wr_chan u_wr_chan (
    .ctrl_m_axi_aclk    (ctrl_m_axi_aclk),
    .ctrl_m_axi_aresetn (ctrl_m_axi_aresetn),
    .req                (state == WR_REQ),
    .resp               (state == WR_RESP),
    .awready            (ctrl_m_axi_awready),
    .wready             (ctrl_m_axi_wready),
    .bvalid             (ctrl_m_axi_bvalid),
    .awvalid            (ctrl_m_axi_awvalid),
    .wvalid             (ctrl_m_axi_wvalid),
    .bready             (ctrl_m_axi_bready),
    .req_done           (wr_req_done),
    .b_done             (wr_b_done)
  );
  // ready_en keeps cmd_ready low while reset is held, even though the state is IDLE
  assign cmd_ready          = (state == IDLE) & ready_en;
  assign accept             = cmd_valid & cmd_ready;
  assign busy               = state != IDLE;
  assign rsp_valid          = state == RESP;
  assign ctrl_m_axi_arvalid = state == RD_REQ;
  assign ctrl_m_axi_rready  = state == RD_DATA;
  assign ctrl_m_axi_awaddr  = addr_q;
  assign ctrl_m_axi_araddr  = addr_q;
  assign ctrl_m_axi_wdata   = wdata_q;
  assign ctrl_m_axi_wstrb   = 4'hF;
  assign is_poll            = op_q == OP_POLL;
  assign tmo                = phase_cnt == TMO_LAST;
  assign rd_stop            = ctrl_m_axi_rresp[1] | poll_hit(ctrl_m_axi_rdata, mask_q, expect_q);
  assign poll_last          = poll_cnt + 16'd1 == POLLS;
  always_comb begin
    state_n  = state;
    tmo_fire = 1'b0;
    case (state)
      IDLE:     state_n = accept ? (cmd_op == OP_WRITE ? WR_REQ : RD_REQ) : IDLE;
      WR_REQ: begin
        tmo_fire = tmo & ~wr_req_done;
        state_n  = wr_req_done ? WR_RESP : tmo ? RESP : WR_REQ;
      end
      WR_RESP: begin
        tmo_fire = tmo & ~wr_b_done;
        state_n  = (wr_b_done | tmo) ? RESP : WR_RESP;
      end
      RD_REQ: begin
        tmo_fire = tmo & ~ctrl_m_axi_arready;
        state_n  = ctrl_m_axi_arready ? RD_DATA : tmo ? RESP : RD_REQ;
      end
      RD_DATA: begin
        tmo_fire = tmo & ~ctrl_m_axi_rvalid;
        state_n  = !ctrl_m_axi_rvalid ? (tmo ? RESP : RD_DATA) :
                   (!is_poll || rd_stop || poll_last) ? RESP : POLL_GAP;
      end
      POLL_GAP: state_n = gap_cnt == GAP_LAST ? RD_REQ : POLL_GAP;
      RESP:     state_n = rsp_ready ? IDLE : RESP;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge ctrl_m_axi_aclk or negedge ctrl_m_axi_aresetn) begin
    if (!ctrl_m_axi_aresetn) begin
      state      <= IDLE;
      ready_en   <= 1'b0;
      op_q       <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      mask_q     <= 32'h0;
      expect_q   <= 32'h0;
      phase_cnt  <= 16'h0;
      gap_cnt    <= 16'h0;
      poll_cnt   <= 16'h0;
      rsp_rdata  <= 32'h0;
      rsp_resp   <= 2'b00;
      rsp_status <= ST_OK;
    end else begin
      state     <= state_n;
      ready_en  <= 1'b1;
      phase_cnt <= (state_n != state) ? 16'h0 : phase_cnt + 16'd1;
      gap_cnt   <= (state == POLL_GAP) ? gap_cnt + 16'd1 : 16'h0;
      if (accept) begin
        op_q       <= cmd_op;
        addr_q     <= cmd_addr;
        wdata_q    <= cmd_wdata;
        mask_q     <= cmd_mask;
        expect_q   <= cmd_expect;
        poll_cnt   <= 16'h0;
        rsp_rdata  <= 32'h0;
        rsp_resp   <= 2'b00;
        rsp_status <= ST_OK;
      end
      if (state == WR_RESP && wr_b_done) rsp_resp <= ctrl_m_axi_bresp;
      if (state == RD_DATA && ctrl_m_axi_rvalid) begin
        rsp_rdata <= ctrl_m_axi_rdata;
        rsp_resp  <= ctrl_m_axi_rresp;
        poll_cnt  <= poll_cnt + 16'd1;
        if (is_poll && !rd_stop && poll_last) rsp_status <= ST_POLL_FAIL;
      end
      if (tmo_fire) begin
        rsp_status <= ST_TIMEOUT;
        rsp_resp   <= AXI_SLVERR;
      end
    end
  end
endmodule

// File: tb/tb_udt_ctrl_axil_master.sv
// tb_udt_ctrl_axil_master: table-driven plus randomized check of the AXI-Lite master
// against a delay-configurable slave and a command-level reference model.
module tb_udt_ctrl_axil_master;
  localparam int T  = 100;
  localparam int P  = 16;
  localparam int MP = 4;
  typedef struct {
    logic [1:0] op; logic [31:0] addr, wdata, mask, expv, v0, v1, v2, v3;
    logic [1:0] rr, br; int awd, wd, ard, rdl;
    logic [31:0] x_rdata; logic [1:0] x_resp, x_st; int x_nar;
  } vec_t;
  logic clk = 1'b0, aresetn = 1'b1;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, busy;
  logic [1:0] cmd_op = 0, rsp_resp, rsp_status;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0, cmd_mask = 0, cmd_expect = 0, rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  int n_vec = 0, n_bad = 0, cyc = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0, r_base = 0;
  bit b_never = 0;
  logic [1:0] bresp_cfg = 0, rresp_cfg = 0;
  logic [31:0] rd_vals [4];
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, aw_c, w_c, b_c, ar_c, r_c;
  int ar_cyc [1024], r_cyc [1024];
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0] last_wstrb;
  bit aw_got, w_got, pend_r;
  udt_ctrl_axil_master #(.TIMEOUT_CYCLES(T), .POLL_INTERVAL(P), .MAX_POLLS(MP), .ADDR_W(32)) dut (
    .ctrl_m_axi_aclk(clk), .ctrl_m_axi_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask), .cmd_expect(cmd_expect),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_status(rsp_status), .busy(busy),
    .ctrl_m_axi_awaddr(awaddr), .ctrl_m_axi_awvalid(awvalid), .ctrl_m_axi_awready(awready),
    .ctrl_m_axi_wdata(wdata), .ctrl_m_axi_wstrb(wstrb), .ctrl_m_axi_wvalid(wvalid), .ctrl_m_axi_wready(wready),
    .ctrl_m_axi_bresp(bresp), .ctrl_m_axi_bvalid(bvalid), .ctrl_m_axi_bready(bready),
    .ctrl_m_axi_araddr(araddr), .ctrl_m_axi_arvalid(arvalid), .ctrl_m_axi_arready(arready),
    .ctrl_m_axi_rdata(rdata), .ctrl_m_axi_rresp(rresp), .ctrl_m_axi_rvalid(rvalid), .ctrl_m_axi_rready(rready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // slave write side: ready after a per-channel delay, B after both AW and W seen
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      awready <= 0; wready <= 0; bvalid <= 0; bresp <= 0;
      aw_got <= 0; w_got <= 0; aw_c <= 0; w_c <= 0; b_c <= 0;
    end else begin
      awready <= 0;
      wready <= 0;
      if (awvalid && awready) begin
        aw_got <= 1; n_aw <= n_aw + 1; last_awaddr <= awaddr; aw_c <= 0;
      end else if (awvalid) begin
        if (aw_c >= aw_dly) awready <= 1; else aw_c <= aw_c + 1;
      end
      if (wvalid && wready) begin
        w_got <= 1; n_w <= n_w + 1; last_wdata <= wdata; last_wstrb <= wstrb; w_c <= 0;
      end else if (wvalid) begin
        if (w_c >= w_dly) wready <= 1; else w_c <= w_c + 1;
      end
      if (bvalid && bready) begin
        bvalid <= 0; aw_got <= 0; w_got <= 0; n_b <= n_b + 1; b_c <= 0;
      end else if (aw_got && w_got && !bvalid && !b_never) begin
        if (b_c >= b_dly) begin bvalid <= 1; bresp <= bresp_cfg; end else b_c <= b_c + 1;
      end
    end
  end
  // slave read side: successive reads of one command return rd_vals[0..3], last one repeating
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      arready <= 0; rvalid <= 0; rdata <= 0; rresp <= 0; pend_r <= 0; ar_c <= 0; r_c <= 0;
    end else begin
      arready <= 0;
      if (arvalid && arready) begin
        ar_cyc[n_ar % 1024] <= cyc; n_ar <= n_ar + 1; last_araddr <= araddr; pend_r <= 1; ar_c <= 0; r_c <= 0;
      end else if (arvalid) begin
        if (ar_c >= ar_dly) arready <= 1; else ar_c <= ar_c + 1;
      end
      if (rvalid && rready) begin
        rvalid <= 0; pend_r <= 0; r_cyc[n_r % 1024] <= cyc; n_r <= n_r + 1;
      end else if (pend_r && !rvalid) begin
        if (r_c >= r_dly) begin
          rvalid <= 1; rresp <= rresp_cfg; rdata <= rd_vals[(n_r - r_base) > 3 ? 3 : (n_r - r_base)];
        end else r_c <= r_c + 1;
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic vec_t model(input vec_t v);
    logic [31:0] vals [4];
    vals = '{v.v0, v.v1, v.v2, v.v3};
    v.x_st = 2'b00; v.x_nar = 0; v.x_rdata = 32'h0; v.x_resp = v.br;
    if (v.op == 2'b00) return v;
    for (int i = 0; i < MP; i++) begin
      v.x_nar = i + 1; v.x_rdata = vals[i < 3 ? i : 3]; v.x_resp = v.rr;
      if (v.op != 2'b10 || v.rr[1] || ((v.x_rdata ^ v.expv) & v.mask) == 32'h0) return v;
    end
    v.x_st = 2'b10;
    return v;
  endfunction
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] a, wd, m, e, input int hold,
                        output logic [31:0] rd, output logic [1:0] rs, st, output int lat);
    int n, t0;
    logic [31:0] snap;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = m; cmd_expect = e; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready", cmd_ready, 1);
    t0 = cyc;
    @(negedge clk);
    cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_mask = $urandom; cmd_expect = $urandom;
    chk("cmd_ready_drop", cmd_ready, 0);
    n = 0;
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_busy", busy, 1);
    chk("axi_quiet_in_rsp", {awvalid, wvalid, bready, arvalid, rready}, 0);
    lat = cyc - t0;
    rd = rsp_rdata; rs = rsp_resp; st = rsp_status;
    snap = {26'h0, rsp_valid, busy, rsp_status, rsp_resp};
    repeat (hold) begin
      @(negedge clk);
      chk("rsp_hold_ctl", {26'h0, rsp_valid, busy, rsp_status, rsp_resp}, snap);
      chk("rsp_hold_data", rsp_rdata, rd);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("idle_after_rsp", {busy, rsp_valid, cmd_ready}, 3'b001);
  endtask
  task automatic apply(input vec_t v, input int hold);
    int a0, r0, aw0, w0, b0, lat;
    logic [31:0] rd;
    logic [1:0] rs, st;
    aw_dly = v.awd; w_dly = v.wd; ar_dly = v.ard; r_dly = v.rdl; b_dly = v.rdl;
    bresp_cfg = v.br; rresp_cfg = v.rr; rd_vals = '{v.v0, v.v1, v.v2, v.v3};
    a0 = n_ar; r0 = n_r; aw0 = n_aw; w0 = n_w; b0 = n_b; r_base = n_r;
    do_cmd(v.op, v.addr, v.wdata, v.mask, v.expv, hold, rd, rs, st, lat);
    chk("rdata", rd, v.x_rdata);
    chk("resp", rs, v.x_resp);
    chk("status", st, v.x_st);
    chk("ar_count", n_ar - a0, v.x_nar);
    chk("aw_w_b_count", {n_aw - aw0, n_w - w0, n_b - b0}, (v.op == 2'b00) ? {32'd1, 32'd1, 32'd1} : 96'h0);
    if (v.op == 2'b00) begin
      chk("awaddr", last_awaddr, v.addr);
      chk("wdata", last_wdata, v.wdata);
      chk("wstrb", last_wstrb, 4'hF);
    end else chk("araddr", last_araddr, v.addr);
    // arready lags arvalid by one cycle, so a full gap puts >= P+2 cycles between R and next AR
    for (int j = 0; j < v.x_nar - 1; j++)
      chk("poll_gap", (ar_cyc[(a0 + j + 1) % 1024] - r_cyc[(r0 + j) % 1024]) >= P + 2, 1);
  endtask
  initial begin
    vec_t tbl [10];
    vec_t v;
    int n, seen, lat;
    logic [31:0] rd;
    logic [1:0] rs, st;
    tbl[0] = '{2'b00, 32'd1, 32'd16384, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 2, 0, 0, 32'h0, 2'b00, 2'b00, 0};
    tbl[1] = '{2'b00, 32'd6, 32'd1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b10, 3, 0, 0, 1, 32'h0, 2'b10, 2'b00, 0};
    tbl[2] = '{2'b00, 32'd4, 32'd1400, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 1, 1, 0, 2, 32'h0, 2'b00, 2'b00, 0};
    tbl[3] = '{2'b01, 32'd7, 32'h0, 32'h0, 32'h0, 32'h5, 32'h5, 32'h5, 32'h5, 2'b00, 2'b00, 0, 0, 2, 3, 32'h5, 2'b00, 2'b00, 1};
    tbl[4] = '{2'b10, 32'd7, 32'h0, 32'hFFFF_FFFF, 32'h10, 32'h1, 32'h1, 32'h10, 32'h10, 2'b00, 2'b00, 0, 0, 1, 0, 32'h10, 2'b00, 2'b00, 3};
    tbl[5] = '{2'b10, 32'd7, 32'h0, 32'hFFFF_FFFF, 32'h10, 32'h1, 32'h1, 32'h1, 32'h1, 2'b00, 2'b00, 0, 0, 0, 1, 32'h1, 2'b00, 2'b10, 4};
    tbl[6] = '{2'b10, 32'd0, 32'h0, 32'hFFFF_FFFF, 32'h10, 32'h1, 32'h1, 32'h1, 32'h1, 2'b10, 2'b00, 0, 0, 0, 0, 32'h1, 2'b10, 2'b00, 1};
    tbl[7] = '{2'b11, 32'd0, 32'h0, 32'h0, 32'h0, 32'h1000, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0, 32'h1000, 2'b00, 2'b00, 1};
    tbl[8] = '{2'b10, 32'd7, 32'h0, 32'h0000_00F0, 32'h10, 32'h3, 32'h1F, 32'h3, 32'h3, 2'b00, 2'b00, 0, 0, 0, 2, 32'h1F, 2'b00, 2'b00, 2};
    tbl[9] = '{2'b01, 32'd5, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 2'b10, 2'b00, 0, 0, 2, 0, 32'hDEAD_BEEF, 2'b10, 2'b00, 1};
    #1 aresetn = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {cmd_ready, rsp_valid, busy, awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("reset_rsp", {rsp_status, rsp_resp}, 0);
    chk("reset_rdata", rsp_rdata, 0);
    aresetn = 1;
    foreach (tbl[i]) apply(tbl[i], i % 3);
    for (int k = 0; k < 30; k++) begin
      v.op = 2'($urandom_range(0, 3)); v.addr = $urandom_range(0, 7); v.wdata = $urandom;
      v.mask = $urandom | 32'h1; v.expv = $urandom;
      v.v0 = ($urandom_range(0, 2) == 0) ? v.expv ^ ($urandom & ~v.mask) : $urandom;
      v.v1 = ($urandom_range(0, 2) == 0) ? v.expv ^ ($urandom & ~v.mask) : $urandom;
      v.v2 = ($urandom_range(0, 2) == 0) ? v.expv ^ ($urandom & ~v.mask) : $urandom;
      v.v3 = ($urandom_range(0, 2) == 0) ? v.expv ^ ($urandom & ~v.mask) : $urandom;
      v.rr = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
      v.br = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
      v.awd = $urandom_range(0, 3); v.wd = $urandom_range(0, 3);
      v.ard = $urandom_range(0, 3); v.rdl = $urandom_range(0, 3);
      apply(model(v), $urandom_range(0, 2));
    end
    // write whose B never arrives: timeout path
    b_never = 1; aw_dly = 0; w_dly = 0;
    do_cmd(2'b00, 32'd2, 32'h1234, 32'h0, 32'h0, 2, rd, rs, st, lat);
    chk("tmo_status", st, 2'b01);
    chk("tmo_resp", rs, 2'b10);
    chk("tmo_latency", (lat >= T) && (lat <= T + 8), 1);
    b_never = 0;
    @(negedge clk); aresetn = 0;
    repeat (2) @(negedge clk);
    aresetn = 1;
    // reset while waiting in RD_DATA
    ar_dly = 0; r_dly = 40; rresp_cfg = 0; rd_vals = '{32'h77, 32'h77, 32'h77, 32'h77}; r_base = n_r;
    @(negedge clk);
    cmd_op = 2'b01; cmd_addr = 3; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 0;
    n = 0;
    while (!rready && n < 50) begin @(negedge clk); n++; end
    chk("rd_data_reached", rready, 1);
    #2 aresetn = 0;
    #1;
    chk("async_rst_ctl", {cmd_ready, rsp_valid, busy, awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("async_rst_rsp", {rsp_status, rsp_resp}, 0);
    chk("async_rst_rdata", rsp_rdata, 0);
    @(negedge clk);
    aresetn = 1;
    seen = 0;
    repeat (50) begin @(negedge clk); if (rsp_valid || busy) seen++; end
    chk("no_rsp_after_rst", seen, 0);
    v = '{2'b01, 32'd3, 32'h0, 32'h0, 32'h0, 32'h5A5A, 32'h0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0, 1, 3, 32'h0, 2'b00, 2'b00, 0};
    apply(model(v), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
